// File: rtl/pm_tdr_bank.sv
// pm_tdr_bank: indexed bank of control/status test-data registers behind one shared serial shift path
module pm_tdr_bank #(
  parameter int                            NUM_REGS  = 3,
  parameter int                            REG_WIDTH = 32,
  parameter int                            SEL_W     = 2,
  parameter logic [NUM_REGS-1:0]           RO_MASK   = 3'b100,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VAL = {32'h0, 32'hFFFF_FFFF, 32'h0},
  parameter int                            IRQ_BIT   = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  output logic                          serial_out,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          capture,
  input  logic                          shift,
  input  logic                          update,
  input  logic [NUM_REGS-1:0]           par_load_en,
  input  logic [NUM_REGS*REG_WIDTH-1:0] par_load_data,
  input  logic [NUM_REGS*REG_WIDTH-1:0] status_in,
  output logic [NUM_REGS*REG_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]           irq,
  output logic                          shift_err
);
  localparam int NSEL = 2 ** SEL_W;
  localparam int CW   = $clog2(REG_WIDTH + 2);
  typedef enum logic [1:0] {IDLE, ARMED, SHIFTING} state_t;
  state_t               state_q, state_d;
  logic [REG_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [REG_WIDTH-1:0] reg_q [NUM_REGS];
  logic [REG_WIDTH-1:0] reg_d [NUM_REGS];
  logic [REG_WIDTH-1:0] cap_src [NSEL];
  logic [NSEL-1:0]      ro_ext;
  logic [NUM_REGS-1:0]  irq_d, irq_q;
  logic                 do_shift, do_upd, commit, clash, shift_err_d, shift_err_q;
  // Unused select codes behave as read-only registers that read back as zero
  for (genvar i = 0; i < NSEL; i++) begin : g_sel
    if (i < NUM_REGS) begin : g_v
      assign ro_ext[i]  = RO_MASK[i];
      assign cap_src[i] = RO_MASK[i] ? status_in[i*REG_WIDTH +: REG_WIDTH] : reg_q[i];
    end else begin : g_x
      assign ro_ext[i]  = 1'b1;
      assign cap_src[i] = '0;
    end
  end
  assign do_shift = shift && !capture;
  assign do_upd   = update && !capture && !shift;
  assign commit   = do_upd && state_q != IDLE && cnt_q == CW'(REG_WIDTH) && !ro_ext[sel_q];
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (capture) begin
      state_d = ARMED;
      sel_d   = sel;
      cnt_d   = '0;
      shreg_d = cap_src[sel];
    end else if (do_shift) begin
      shreg_d = {serial_in, shreg_q[REG_WIDTH-1:1]};
      state_d = state_q == IDLE ? IDLE : SHIFTING;
      cnt_d   = state_q == IDLE ? cnt_q : cnt_q + CW'(cnt_q != CW'(REG_WIDTH + 1));
    end else if (do_upd) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    irq_d   = '0;
    clash   = 1'b0;
    reg_out = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      reg_d[k] = par_load_en[k] ? (RO_MASK[k] ? status_in[k*REG_WIDTH +: REG_WIDTH]
                                              : par_load_data[k*REG_WIDTH +: REG_WIDTH])
               : (commit && sel_q == SEL_W'(k)) ? shreg_q : reg_q[k];
      clash    = clash | (commit && sel_q == SEL_W'(k) && par_load_en[k]);
      irq_d[k] = !RO_MASK[k] && (reg_d[k][IRQ_BIT] != reg_q[k][IRQ_BIT]);
      reg_out[k*REG_WIDTH +: REG_WIDTH] = reg_q[k];
    end
    shift_err_d = do_upd && (!commit || clash);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      irq_q       <= '0;
      shift_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      irq_q       <= irq_d;
      shift_err_q <= shift_err_d;
    end
    for (int k = 0; k < NUM_REGS; k++)
      reg_q[k] <= rst ? (RO_MASK[k] ? '0 : RESET_VAL[k*REG_WIDTH +: REG_WIDTH]) : reg_d[k];
  end
  assign serial_out = shreg_q[0];
  assign irq        = irq_q;
  assign shift_err  = shift_err_q;
endmodule

// File: tb/tb_pm_tdr_bank.sv
// tb_pm_tdr_bank: directed and randomized checks of pm_tdr_bank against a transaction-level model
module tb_pm_tdr_bank;
  localparam int N = 3;
  localparam int W = 32;
  localparam logic [N-1:0]   RO = 3'b100;
  localparam logic [N*W-1:0] RV = {32'h0, 32'hFFFF_FFFF, 32'h0};
  logic clk = 1'b0;
  logic rst, serial_in, serial_out, capture, shift, update, shift_err;
  logic [1:0] sel;
  logic [N-1:0] par_load_en, irq;
  logic [N*W-1:0] par_load_data, status_in, reg_out;
  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_reg [N];
  logic [W-1:0] m_sh;
  int m_cnt, m_sel;
  bit m_act;
  logic [N-1:0] m_irq;
  logic m_err;
  logic [W-1:0] got;
  always #5 clk = ~clk;
  pm_tdr_bank dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_out(serial_out), .sel(sel),
    .capture(capture), .shift(shift), .update(update), .par_load_en(par_load_en),
    .par_load_data(par_load_data), .status_in(status_in), .reg_out(reg_out),
    .irq(irq), .shift_err(shift_err)
  );
  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [N*W-1:0] packed_model();
    logic [N*W-1:0] p;
    for (int i = 0; i < N; i++) p[i*W +: W] = m_reg[i];
    return p;
  endfunction
  // One clock edge of the bank, described as transactions rather than state encodings
  task automatic model_step();
    logic [W-1:0] nreg [N];
    logic err;
    if (rst) begin
      for (int i = 0; i < N; i++) m_reg[i] = RO[i] ? '0 : RV[i*W +: W];
      m_sh = '0; m_cnt = 0; m_act = 0; m_sel = 0; m_irq = '0; m_err = 0;
      return;
    end
    err = 0;
    for (int i = 0; i < N; i++)
      nreg[i] = !par_load_en[i] ? m_reg[i] : RO[i] ? status_in[i*W +: W] : par_load_data[i*W +: W];
    if (capture) begin
      m_act = 1; m_sel = int'(sel); m_cnt = 0;
      m_sh = (m_sel >= N) ? '0 : RO[m_sel] ? status_in[m_sel*W +: W] : m_reg[m_sel];
    end else if (shift) begin
      m_sh = {serial_in, m_sh[W-1:1]};
      if (m_act) m_cnt = (m_cnt + 1 > W + 1) ? W + 1 : m_cnt + 1;
    end else if (update) begin
      if (m_act && m_cnt == W && m_sel < N && !RO[m_sel] && !par_load_en[m_sel]) nreg[m_sel] = m_sh;
      else err = 1;
      m_act = 0;
    end
    for (int i = 0; i < N; i++) m_irq[i] = !RO[i] && (nreg[i][10] != m_reg[i][10]);
    m_err = err;
    for (int i = 0; i < N; i++) m_reg[i] = nreg[i];
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("reg_out", reg_out, packed_model());
    check("irq", irq, m_irq);
    check("shift_err", shift_err, m_err);
    check("serial_out", serial_out, m_sh[0]);
    rst = 0; capture = 0; shift = 0; update = 0; par_load_en = '0; serial_in = 0;
  endtask
  task automatic serial_load(input logic [1:0] s, input logic [W-1:0] val, input int n);
    sel = s; capture = 1;
    tick();
    for (int k = 0; k < n; k++) begin
      serial_in = (k < W) ? val[k] : 1'b0;
      shift = 1;
      tick();
    end
  endtask
  initial begin
    rst = 1; capture = 0; shift = 0; update = 0; serial_in = 0; sel = 0;
    par_load_en = '0; par_load_data = '0; status_in = '0;
    tick();
    tick();
    check("rst_reg", reg_out, RV);
    check("rst_irq", irq, 0);
    check("rst_err", shift_err, 0);
    check("rst_sout", serial_out, 0);
    serial_load(2'd0, 32'h0000_0400, 32);
    update = 1;
    tick();
    check("wr0_reg", reg_out[31:0], 32'h0000_0400);
    check("wr0_irq", irq, 3'b001);
    check("wr0_err", shift_err, 0);
    tick();
    check("wr0_irq_end", irq, 0);
    for (int r = 0; r < 2; r++) begin
      serial_load(2'd1, 32'h0, r == 0 ? 31 : 33);
      update = 1;
      tick();
      check("len_reg1", reg_out[63:32], 32'hFFFF_FFFF);
      check("len_err", shift_err, 1);
      tick();
      check("len_err_end", shift_err, 0);
    end
    status_in[95:64] = 32'hDEAD_BEEF;
    sel = 2; capture = 1;
    tick();
    for (int k = 0; k < W; k++) begin
      got[k] = serial_out;
      shift = 1; serial_in = 0;
      tick();
    end
    check("stat_sout", got, 32'hDEAD_BEEF);
    update = 1;
    tick();
    check("stat_err", shift_err, 1);
    check("stat_reg2", reg_out[95:64], 32'h0);
    serial_load(2'd0, 32'h1, 32);
    update = 1; par_load_en = 3'b001; par_load_data[31:0] = 32'h5555;
    tick();
    check("clash_reg0", reg_out[31:0], 32'h5555);
    check("clash_err", shift_err, 1);
    sel = 1; capture = 1; shift = 1; update = 1;
    tick();
    check("prio_err", shift_err, 0);
    check("prio_sout", serial_out, 1);
    serial_load(2'd0, 32'hABCD_1234, 16);
    rst = 1;
    tick();
    check("midrst_reg0", reg_out[31:0], 32'h0);
    update = 1;
    tick();
    check("midrst_err", shift_err, 1);
    check("midrst_reg0b", reg_out[31:0], 32'h0);
    for (int t = 0; t < 250; t++) begin
      int n;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 36)) : W;
      status_in = {$urandom, $urandom, $urandom};
      sel = 2'($urandom_range(0, 3)); capture = 1;
      tick();
      for (int k = 0; k < n; k++) begin
        serial_in = 1'($urandom); shift = 1;
        if ($urandom_range(0, 40) == 0) begin
          par_load_en = 3'($urandom); par_load_data = {$urandom, $urandom, $urandom};
        end
        tick();
      end
      update = 1;
      if ($urandom_range(0, 3) == 0) begin
        par_load_en = 3'($urandom); par_load_data = {$urandom, $urandom, $urandom};
      end
      if ($urandom_range(0, 30) == 0) rst = 1;
      tick();
    end
    for (int t = 0; t < 400; t++) begin
      sel = 2'($urandom_range(0, 3));
      capture = ($urandom_range(0, 9) == 0); shift = 1'($urandom); update = ($urandom_range(0, 5) == 0);
      serial_in = 1'($urandom);
      par_load_en = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      par_load_data = {$urandom, $urandom, $urandom};
      status_in = {$urandom, $urandom, $urandom};
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
